// File: rtl/vx_tag_alloc_insert.sv
// Tag allocator/inserter: lowest free tag of 2^S spliced into the payload at POS; optional stall counter via VX_TAG_ALLOC_INSERT_PERF_EN.
// Latency: one cycle from accept to registered out_valid/out_data/out_tag.
// Backpressure: in_ready = pool non-empty && (!out_valid || out_ready); output holds while stalled.
module vx_tag_alloc_insert #(
  parameter int N   = 32,
  parameter int S   = 2,
  parameter int POS = 0
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           in_valid,
  input  logic [N-1:0]   in_data,
  output logic           in_ready,
  output logic           out_valid,
  output logic [N+S-1:0] out_data,
  output logic [S-1:0]   out_tag,
  input  logic           out_ready,
  input  logic           rel_valid,
  input  logic [S-1:0]   rel_tag,
  output logic [S:0]     free_count,
  output logic           all_free
`ifdef VX_TAG_ALLOC_INSERT_PERF_EN
  ,
  output logic [31:0]    perf_stall_cycles
`endif
);

  localparam int TAGS = 1 << S;
  localparam logic [N:0]   ONE_W   = {{N{1'b0}}, 1'b1};
  localparam logic [N:0]   LO_FULL = (ONE_W << POS) - ONE_W;
  localparam logic [N-1:0] LO_MASK = LO_FULL[N-1:0];

  logic [TAGS-1:0] free_mask_q, free_mask_d;
  logic [S:0]      free_cnt_q, free_cnt_d;
  logic            out_valid_q, out_valid_d;
  logic [N+S-1:0]  out_data_q, out_data_d;
  logic [S-1:0]    out_tag_q, out_tag_d;
  logic            all_free_q, all_free_d;

  logic           adv, acc, rel_eff;
  logic [S-1:0]   pick;
  logic [N+S-1:0] ins_data;

  always_comb begin
    pick = '0;
    for (int i = TAGS - 1; i >= 0; i--) begin
      if (free_mask_q[i]) pick = S'(i);
    end
  end

  // High payload bits move up by S to open a gap at POS for the tag.
  assign ins_data = ((N+S)'(in_data & ~LO_MASK) << S)
                  | (N+S)'(in_data & LO_MASK)
                  | ((N+S)'(pick) << POS);

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = (|free_mask_q) && adv;
  assign acc      = in_valid && in_ready;
  // Releasing a free tag is a no-op, so it never collides with this cycle's pick.
  assign rel_eff  = rel_valid && !free_mask_q[rel_tag];

  always_comb begin
    free_mask_d = free_mask_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    if (acc) begin
      free_mask_d[pick] = 1'b0;
      out_valid_d       = 1'b1;
      out_data_d        = ins_data;
      out_tag_d         = pick;
    end else if (adv) begin
      out_valid_d = 1'b0;
    end
    if (rel_eff) free_mask_d[rel_tag] = 1'b1;
    free_cnt_d = free_cnt_q + (S+1)'(rel_eff) - (S+1)'(acc);
    all_free_d = (free_cnt_d == (S+1)'(TAGS));
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      free_mask_q <= '1;
      free_cnt_q  <= (S+1)'(TAGS);
      all_free_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
    end else begin
      free_mask_q <= free_mask_d;
      free_cnt_q  <= free_cnt_d;
      all_free_q  <= all_free_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_tag    = out_tag_q;
  assign free_count = free_cnt_q;
  assign all_free   = all_free_q;

`ifdef VX_TAG_ALLOC_INSERT_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (in_valid && !in_ready && perf_q != '1) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) perf_q <= '0;
    else         perf_q <= perf_d;
  end

  assign perf_stall_cycles = perf_q;
`endif

endmodule

// File: tb/tb_vx_tag_alloc_insert.sv
// Bench for vx_tag_alloc_insert (N=8, S=2, POS=3): directed steps then random traffic against a set-based model.
module tb_vx_tag_alloc_insert;
  localparam int N = 8, S = 2, POS = 3, T = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           resetn, in_valid, in_ready, out_valid, out_ready, rel_valid, all_free;
  logic [N-1:0]   in_data;
  logic [N+S-1:0] out_data;
  logic [S-1:0]   out_tag, rel_tag;
  logic [S:0]     free_count;
`ifdef VX_TAG_ALLOC_INSERT_PERF_EN
  logic [31:0]    perf_stall_cycles;
`endif

  vx_tag_alloc_insert #(.N(N), .S(S), .POS(POS)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_tag(out_tag), .out_ready(out_ready),
    .rel_valid(rel_valid), .rel_tag(rel_tag),
    .free_count(free_count), .all_free(all_free)
`ifdef VX_TAG_ALLOC_INSERT_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Model: a set of free tags plus the visible output item.
  bit          m_free[T];
  logic        m_ov;
  logic [9:0]  m_od;
  logic [1:0]  m_ot;
  int          m_perf;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic int nfree();
    int c = 0;
    for (int i = 0; i < T; i++) c += int'(m_free[i]);
    return c;
  endfunction

  function automatic logic [9:0] spliced(input int d, input int t);
    return 10'(((d >> POS) << (POS + S)) + (t << POS) + (d % (1 << POS)));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < T; i++) m_free[i] = 1'b1;
    m_ov = 1'b0; m_od = '0; m_ot = '0; m_perf = 0;
  endtask

  task automatic cyc(input logic iv, input logic [7:0] id, input logic ordy,
                     input logic rv, input logic [1:0] rt, input logic rn);
    bit rdy, was_free;
    int t;
    in_valid = iv; in_data = id; out_ready = ordy; rel_valid = rv; rel_tag = rt; resetn = rn;
    #1;
    rdy = (nfree() > 0) && (!m_ov || ordy);
    check("in_ready", 32'(in_ready), 32'(rdy));
    if (!rn) begin
      model_reset();
    end else begin
      if (iv && !rdy) m_perf++;
      was_free = m_free[rt];
      if (iv && rdy) begin
        t = 0;
        while (!m_free[t]) t++;
        m_free[t] = 1'b0;
        m_ov = 1'b1; m_od = spliced(int'(id), t); m_ot = 2'(t);
      end else if (!m_ov || ordy) begin
        m_ov = 1'b0;
      end
      if (rv && !was_free) m_free[rt] = 1'b1;
    end
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("out_data", 32'(out_data), 32'(m_od));
    check("out_tag", 32'(out_tag), 32'(m_ot));
    check("free_count", 32'(free_count), 32'(nfree()));
    check("all_free", 32'(all_free), 32'(nfree() == T));
`ifdef VX_TAG_ALLOC_INSERT_PERF_EN
    check("perf_stall", perf_stall_cycles, 32'(m_perf));
`endif
  endtask

  logic [9:0] held_data;
  logic [1:0] held_tag;

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; rel_valid = 1'b0; rel_tag = '0;
    @(posedge clk);
    #1;
    model_reset();

    // Reset state, with a release that must be ignored.
    cyc(0, 8'h00, 1, 1, 2'd2, 0);
    check("rst_free_count", 32'(free_count), 32'd4);
    check("rst_all_free", 32'(all_free), 32'd1);

    // Single transfer.
    cyc(1, 8'hA5, 1, 0, 2'd0, 1);
    check("single_data", 32'(out_data), 32'h285);
    check("single_tag", 32'(out_tag), 32'd0);
    check("single_count", 32'(free_count), 32'd3);
    cyc(0, 8'h00, 1, 1, 2'd0, 1);

    // Back-to-back: tags 0..3.
    cyc(1, 8'hA5, 1, 0, 2'd0, 1);
    cyc(1, 8'hA5, 1, 0, 2'd0, 1);
    check("b2b_second_data", 32'(out_data), 32'h28D);
    cyc(1, 8'hA5, 1, 0, 2'd0, 1);
    cyc(1, 8'hA5, 1, 0, 2'd0, 1);
    check("b2b_last_tag", 32'(out_tag), 32'd3);
    check("b2b_empty_ready", 32'(in_ready), 32'd0);
    check("b2b_empty_count", 32'(free_count), 32'd0);
    check("b2b_empty_all_free", 32'(all_free), 32'd0);

    // Release 2, double release, reuse.
    cyc(1, 8'h5A, 1, 1, 2'd2, 1);
    check("rel_ready_next", 32'(in_ready), 32'd1);
    cyc(0, 8'h00, 1, 1, 2'd2, 1);
    check("double_rel_count", 32'(free_count), 32'd1);
    cyc(1, 8'h3C, 1, 0, 2'd0, 1);
    check("reuse_tag", 32'(out_tag), 32'd2);
    cyc(0, 8'h00, 1, 1, 2'd0, 1);
    cyc(0, 8'h00, 1, 1, 2'd1, 1);

    // Backpressure.
    cyc(1, 8'h11, 1, 0, 2'd0, 1);
    held_data = out_data; held_tag = out_tag;
    for (int i = 0; i < 3; i++) cyc(1, 8'h22, 0, 0, 2'd0, 1);
    check("bp_data_stable", 32'(out_data), 32'(held_data));
    check("bp_tag_stable", 32'(out_tag), 32'(held_tag));
    check("bp_ready_low", 32'(in_ready), 32'd0);
    cyc(1, 8'h22, 1, 0, 2'd0, 1);
    check("bp_release_load", 32'(out_data), 32'(spliced(8'h22, 1)));

    // Simultaneous accept and release.
    cyc(0, 8'h00, 1, 1, 2'd3, 1);
    cyc(1, 8'h33, 1, 1, 2'd0, 1);
    check("simul_tag", 32'(out_tag), 32'd3);
    check("simul_count", 32'(free_count), 32'd1);

    // Reset with tags outstanding and out_valid high.
    cyc(0, 8'h00, 0, 0, 2'd0, 0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_count", 32'(free_count), 32'd4);
    check("midrst_all_free", 32'(all_free), 32'd1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom % 4) != 0, 8'($urandom), ($urandom % 4) != 0,
          ($urandom % 3) == 0, 2'($urandom), ($urandom % 64) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vx_tag_alloc_insert.md
# vx_tag_alloc_insert

Streaming tag allocator and inserter. It accepts an N-bit payload stream, allocates the lowest-index free tag from a pool of 2^S tags, and emits the payload with the tag spliced in at bit position POS. The output stage is registered. Tags return to the pool through a release port. It sits in front of request paths that must match out-of-order responses (memory, cache and fabric request queues) and replaces ad-hoc tag counters.

## Interface
- N, default 32: payload width, at least 1.
- S, default 2: tag width, at least 1; the pool holds 2^S tags.
- POS, default 0: insertion bit position, 0..N inclusive.
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  synchronous reset, active-low.
- in_valid  in  1  payload valid.
- in_data  in  N  payload.
- in_ready  out  1  payload accepted when in_valid && in_ready.
- out_valid  out  1  tagged payload valid.
- out_data  out  N+S  payload with tag inserted.
  - POS=0: {data, tag}.
  - POS=N: {tag, data}.
  - Otherwise: {data[N-1:POS], tag, data[POS-1:0]}.
- out_tag  out  S  allocated tag (same value as the inserted field).
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- rel_valid  in  1  tag release strobe; always accepted.
- rel_tag  in  S  tag being released.
- free_count  out  S+1  number of free tags.
- all_free  out  1  high when every tag is free (drain indicator).

## Operation
- State:
  - free_mask[2^S]: 1 = free.
  - free_count.
  - Output register: out_valid, out_data, out_tag.
- Stage advance: adv = !out_valid || out_ready.
- in_ready = (free_mask != 0) && adv. It is combinational from out_ready and free_mask; it does not depend on in_valid.
- Accept, when in_valid && in_ready:
  - Pick the lowest set index t in free_mask.
  - Clear free_mask[t].
  - Load out_data with in_data with t inserted at POS.
  - Set out_tag = t and out_valid = 1.
- If adv && !(in_valid && in_ready), clear out_valid. out_data and out_tag hold their values.
- Release, when rel_valid:
  - Set free_mask[rel_tag].
  - The freed tag becomes allocatable the cycle after the release edge. There is no same-cycle bypass.
- Release of a tag that is already free: free_mask and free_count are unchanged.
- Simultaneous accept and release: both apply.
  - free_count' = free_count + rel_eff − acc, where rel_eff = rel_valid && !free_mask[rel_tag].
  - The released tag cannot be the tag allocated in the same cycle.
- Empty pool (free_mask == 0): in_ready = 0. The output register drains normally.
- all_free = (free_count == 2^S).
- Reset values, applied when resetn = 0 at a clock edge:
  - out_valid = 0, out_data = 0, out_tag = 0.
  - free_mask all ones, free_count = 2^S, all_free = 1.
  - Reset during an active transfer drops the in-flight output and reclaims every outstanding tag.
  - Releases asserted during reset are ignored.

## Timing
- Latency: accept at edge k, then out_valid is high after edge k.
- Throughput: one payload per cycle while tags are free and out_ready = 1.
- out_valid and out_data stay stable while out_valid && !out_ready.
- free_count and all_free are registered; they reflect an accept or release one cycle after the edge.
- Combinational path: out_ready → in_ready only.

## Configuration
- VX_TAG_ALLOC_INSERT_PERF_EN defined:
  - Adds output perf_stall_cycles, 32 bits, reset 0.
  - It increments each cycle in which in_valid && !in_ready, and saturates at 2^32−1.
- Undefined: the port and the counter are absent. Functional behaviour is identical.

## Test plan
All scenarios use N=8, S=2, POS=3.
- Single transfer: in_data=0xA5 with out_ready=1.
  - Next cycle: out_valid=1, out_tag=0, out_data=0x285, free_count=3.
- Back-to-back: in_data=0xA5 on 4 consecutive cycles, out_ready=1, no release.
  - Tags 0,1,2,3 are issued; the second out_data=0x28D.
  - Then in_ready=0, free_count=0, all_free=0.
- Release and reuse: with the pool empty, release tag 2 at edge k.
  - in_ready=1 in cycle k+1; the next accept gets out_tag=2.
  - Releasing tag 2 again while it is free leaves free_count unchanged.
- Backpressure: hold out_ready=0 with out_valid=1.
  - out_data and out_tag stay stable and in_ready=0.
  - Raise out_ready with in_valid=1: the new item loads in the same cycle.
- Simultaneous: accept and release of an outstanding tag in one cycle.
  - free_count is unchanged; the allocated tag is the lowest free tag before the edge.
- Reset mid-run: resetn=0 with 3 tags outstanding and out_valid=1.
  - Next cycle: out_valid=0, free_count=4, all_free=1, and perf_stall_cycles=0 when the macro is defined.
